// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and default frame constants.
// Defining UART_TX_PARITY_EN adds the PARITY state, which widens the state to 3 bits.
package uart_pkg;
  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 8;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    START  = 3'b001,
    DATA   = 3'b010,
    STOP   = 3'b011,
    PARITY = 3'b100
  } tx_state_e;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } tx_state_e;
`endif
endpackage

// File: rtl/uart_transmitter_if.sv
// Write/status bundle between a byte producer (master) and the UART transmitter (slave).
interface uart_transmitter_if import uart_pkg::*; #(
  parameter int DATA_BITS = UART_DATA_BITS
);
  logic [DATA_BITS-1:0] data_in;
  logic                 load;
  logic                 serial_out;
  logic                 not_ready_out;
  logic                 tx_busy;
  logic                 error1;

  modport master (output data_in, load,
                  input  serial_out, not_ready_out, tx_busy, error1);
  modport slave  (input  data_in, load,
                  output serial_out, not_ready_out, tx_busy, error1);
endinterface

// File: rtl/uart_bit_timer.sv
// Oversample counter: runs 0..OVERSAMPLE-1 and pulses bit_end on the last sample of a bit.
// Held at zero while clear is high, so the first bit after clear is a full bit time.
module uart_bit_timer import uart_pkg::*; #(
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic sample_clk,
  input  logic rstn,
  input  logic clear,
  output logic bit_end
);
  localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

  logic [CW-1:0] sample_cnt;

  assign bit_end = !clear && (sample_cnt == CW'(OVERSAMPLE-1));

  always_ff @(posedge sample_clk or negedge rstn) begin
    if (!rstn)                 sample_cnt <= '0;
    else if (clear || bit_end) sample_cnt <= '0;
    else                       sample_cnt <= sample_cnt + 1'b1;
  end
endmodule

// File: rtl/uart_transmitter.sv
// Buffered 8N1 UART transmitter: holding register + shift register, registered outputs.
// Optional even parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_transmitter import uart_pkg::*; #(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int STOP_BITS  = 1
) (
  input  logic             sample_clk,
  input  logic             rstn,
  uart_transmitter_if.slave tx
);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  tx_state_e            state, state_nxt;
  logic [DATA_BITS-1:0] hold_reg, shift_reg, shift_nxt;
  logic [BW-1:0]        bit_cnt, bit_cnt_nxt;
  logic                 hold_full, serial_q, serial_nxt, busy_q, err_q;
  logic                 bit_end, xfer, accept;
`ifdef UART_TX_PARITY_EN
  logic                 par_q;
`endif

  uart_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_timer (
    .sample_clk (sample_clk),
    .rstn       (rstn),
    .clear      (state == IDLE),
    .bit_end    (bit_end)
  );

  // xfer moves the holding register into the shift register; a write on the same edge still fits.
  assign accept = tx.load && (!hold_full || xfer);

  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift_reg;
    bit_cnt_nxt = bit_cnt;
    serial_nxt  = serial_q;
    xfer        = 1'b0;
    case (state)
      IDLE: begin
        serial_nxt = 1'b1;
        if (hold_full) begin
          xfer       = 1'b1;
          state_nxt  = START;
          serial_nxt = 1'b0;
        end
      end
      START: if (bit_end) begin
        state_nxt  = DATA;
        serial_nxt = shift_reg[0];
      end
      DATA: if (bit_end) begin
        shift_nxt = shift_reg >> 1;
        if (bit_cnt == BW'(DATA_BITS-1)) begin
          bit_cnt_nxt = '0;
`ifdef UART_TX_PARITY_EN
          state_nxt   = PARITY;
          serial_nxt  = par_q;
`else
          state_nxt   = STOP;
          serial_nxt  = 1'b1;
`endif
        end else begin
          bit_cnt_nxt = bit_cnt + 1'b1;
          serial_nxt  = shift_nxt[0];
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) begin
        state_nxt  = STOP;
        serial_nxt = 1'b1;
      end
`endif
      STOP: if (bit_end) begin
        if (bit_cnt == BW'(STOP_BITS-1)) begin
          bit_cnt_nxt = '0;
          // Queued byte starts right after the stop bit, no idle gap.
          if (hold_full) begin
            xfer       = 1'b1;
            state_nxt  = START;
            serial_nxt = 1'b0;
          end else begin
            state_nxt  = IDLE;
            serial_nxt = 1'b1;
          end
        end else begin
          bit_cnt_nxt = bit_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (xfer) shift_nxt = hold_reg;
  end

  always_ff @(posedge sample_clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      serial_q  <= 1'b1;
      hold_reg  <= '0;
      hold_full <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      bit_cnt   <= bit_cnt_nxt;
      serial_q  <= serial_nxt;
      busy_q    <= (state_nxt != IDLE);
      if (accept)    begin hold_reg <= tx.data_in; hold_full <= 1'b1; end
      else if (xfer) hold_full <= 1'b0;
      if (tx.load && !accept) err_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
      if (xfer) par_q <= ^hold_reg;
`endif
    end
  end

  assign tx.serial_out    = serial_q;
  assign tx.not_ready_out = hold_full;
  assign tx.tx_busy       = busy_q;
  assign tx.error1        = err_q;
endmodule

// File: tb/tb_uart_transmitter.sv
// Scenario bench for uart_transmitter: frames are captured off the line per cycle
// and compared against bytes queued when each load was driven.
module tb_uart_transmitter;
  localparam int OS = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * OS;

  logic sample_clk = 1'b0;
  logic rstn = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic [7:0] exp_q[$];

  uart_transmitter_if #(.DATA_BITS(8)) tif();

  uart_transmitter #(.DATA_BITS(8), .OVERSAMPLE(OS), .STOP_BITS(1)) dut (
    .sample_clk (sample_clk),
    .rstn       (rstn),
    .tx         (tif)
  );

  always #5 sample_clk = ~sample_clk;
  always @(posedge sample_clk) cyc <= cyc + 1;

  function automatic logic [NB-1:0] frame_of(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {1'b1, d, 1'b0};
`endif
  endfunction

  // Called on a negedge; waits for a start bit, then samples NB*OS cycles of the line.
  task automatic capture(input int budget, output logic found, output logic [NB-1:0] bits,
                         output logic steady, output int start_cyc, output int busy_cnt,
                         output logic nr_last);
    int w = 0;
    found = 1'b0; bits = '0; steady = 1'b1; start_cyc = -1; busy_cnt = 0; nr_last = 1'b0;
    while (tif.serial_out !== 1'b0 && w < budget) begin
      @(negedge sample_clk);
      w++;
    end
    if (tif.serial_out !== 1'b0) return;
    found = 1'b1;
    start_cyc = cyc;
    for (int b = 0; b < NB; b++) begin
      for (int k = 0; k < OS; k++) begin
        if (b != 0 || k != 0) @(negedge sample_clk);
        if (k == 0) bits[b] = tif.serial_out;
        else if (tif.serial_out !== bits[b]) steady = 1'b0;
        if (tif.tx_busy === 1'b1) busy_cnt++;
        nr_last = tif.not_ready_out;
      end
    end
  endtask

  task automatic test_reset;
    int lows = 0;
    tif.load = 1'b0;
    tif.data_in = '0;
    rstn = 1'b0;
    repeat (3) @(negedge sample_clk);
    total++;
    if ({tif.serial_out, tif.not_ready_out, tif.tx_busy, tif.error1} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_outputs: got %b want 1000",
               {tif.serial_out, tif.not_ready_out, tif.tx_busy, tif.error1});
    end
    rstn = 1'b1;
    repeat (20) begin
      @(negedge sample_clk);
      if (tif.serial_out !== 1'b1 || tif.tx_busy !== 1'b0) lows++;
    end
    total++;
    if (lows != 0) begin
      bad++;
      $display("FAIL reset_idle_line: got %0d non-idle cycles want 0", lows);
    end
  endtask

  task automatic test_single;
    int n, st, bz;
    logic f, s, nr;
    logic [NB-1:0] bits;
    logic [7:0] e;
    @(negedge sample_clk);
    tif.data_in = 8'hA5; tif.load = 1'b1;
    exp_q.push_back(8'hA5);
    @(negedge sample_clk);
    tif.load = 1'b0;
    n = cyc;
    total++;
    if ({tif.not_ready_out, tif.tx_busy, tif.serial_out} !== 3'b101) begin
      bad++;
      $display("FAIL single_accept: got nr/busy/line %b want 101",
               {tif.not_ready_out, tif.tx_busy, tif.serial_out});
    end
    @(negedge sample_clk);
    total++;
    if (tif.not_ready_out !== 1'b0) begin
      bad++;
      $display("FAIL single_nr_width: got not_ready %b want 0", tif.not_ready_out);
    end
    capture(4, f, bits, s, st, bz, nr);
    total++;
    if (!f || st != n + 1) begin
      bad++;
      $display("FAIL single_latency: got start cycle %0d want %0d", st, n + 1);
    end
    total++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    if (bits !== frame_of(e) || !s) begin
      bad++;
      $display("FAIL single_frame: got %b steady %b want %b steady 1", bits, s, frame_of(e));
    end
    total++;
    if (bz != FL) begin
      bad++;
      $display("FAIL single_busy: got %0d busy cycles want %0d", bz, FL);
    end
    @(negedge sample_clk);
    total++;
    if ({tif.tx_busy, tif.serial_out} !== 2'b01) begin
      bad++;
      $display("FAIL single_idle_after: got busy/line %b want 01", {tif.tx_busy, tif.serial_out});
    end
  endtask

  task automatic test_back_to_back;
    int st1, st2, bz1, bz2;
    logic f1, f2, s1, s2, nr1, nr2;
    logic [NB-1:0] b1, b2;
    logic [7:0] e;
    @(negedge sample_clk);
    tif.data_in = 8'h55; tif.load = 1'b1;
    exp_q.push_back(8'h55);
    @(negedge sample_clk);
    tif.load = 1'b0;
    fork
      capture(4, f1, b1, s1, st1, bz1, nr1);
      begin
        repeat (30) @(negedge sample_clk);
        tif.data_in = 8'h0F; tif.load = 1'b1;
        exp_q.push_back(8'h0F);
        @(negedge sample_clk);
        tif.load = 1'b0;
      end
    join
    capture(4, f2, b2, s2, st2, bz2, nr2);
    total++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    if (!f1 || b1 !== frame_of(e) || !s1) begin
      bad++;
      $display("FAIL b2b_frame1: got %b steady %b want %b", b1, s1, frame_of(e));
    end
    total++;
    if (nr1 !== 1'b1) begin
      bad++;
      $display("FAIL b2b_nr_held: got not_ready %b at last stop cycle want 1", nr1);
    end
    total++;
    if (!f2 || st2 != st1 + FL) begin
      bad++;
      $display("FAIL b2b_gap: got second start %0d want %0d", st2, st1 + FL);
    end
    total++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    if (b2 !== frame_of(e) || !s2 || nr2 !== 1'b0) begin
      bad++;
      $display("FAIL b2b_frame2: got %b steady %b nr %b want %b steady 1 nr 0",
               b2, s2, nr2, frame_of(e));
    end
    total++;
    if (bz1 + bz2 != 2 * FL) begin
      bad++;
      $display("FAIL b2b_busy: got %0d busy cycles want %0d", bz1 + bz2, 2 * FL);
    end
  endtask

  task automatic test_overrun;
    int st1, st2, bz1, bz2;
    logic f1, f2, s1, s2, nr1, nr2, err3;
    logic [NB-1:0] b1, b2;
    logic [7:0] e;
    repeat (3) @(negedge sample_clk);
    tif.data_in = 8'h11; tif.load = 1'b1;
    exp_q.push_back(8'h11);
    @(negedge sample_clk);
    tif.data_in = 8'h22;
    exp_q.push_back(8'h22);
    @(negedge sample_clk);
    total++;
    if (tif.error1 !== 1'b0) begin
      bad++;
      $display("FAIL ovr_no_early_err: got error1 %b want 0", tif.error1);
    end
    err3 = 1'bx;
    fork
      capture(4, f1, b1, s1, st1, bz1, nr1);
      begin
        tif.data_in = 8'h33;
        @(negedge sample_clk);
        err3 = tif.error1;
        tif.load = 1'b0;
      end
    join
    capture(4, f2, b2, s2, st2, bz2, nr2);
    total++;
    if (err3 !== 1'b1) begin
      bad++;
      $display("FAIL ovr_err_set: got error1 %b want 1", err3);
    end
    total++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    if (!f1 || b1 !== frame_of(e) || !s1) begin
      bad++;
      $display("FAIL ovr_frame1: got %b want %b", b1, frame_of(e));
    end
    total++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    if (!f2 || b2 !== frame_of(e) || !s2 || st2 != st1 + FL) begin
      bad++;
      $display("FAIL ovr_frame2: got %b at %0d want %b at %0d", b2, st2, frame_of(e), st1 + FL);
    end
    repeat (5) @(negedge sample_clk);
    total++;
    if (tif.error1 !== 1'b1 || tif.tx_busy !== 1'b0) begin
      bad++;
      $display("FAIL ovr_sticky: got error1/busy %b want 10", {tif.error1, tif.tx_busy});
    end
  endtask

  task automatic test_reset_midframe;
    int n, st, bz;
    logic f, s, nr;
    logic [NB-1:0] bits;
    logic [7:0] e;
    @(negedge sample_clk);
    tif.data_in = 8'hFF; tif.load = 1'b1;
    @(negedge sample_clk);
    tif.load = 1'b0;
    repeat (1 + OS + 3 * OS + 3) @(negedge sample_clk);
    total++;
    if ({tif.tx_busy, tif.error1} !== 2'b11) begin
      bad++;
      $display("FAIL mid_pre_reset: got busy/error1 %b want 11", {tif.tx_busy, tif.error1});
    end
    rstn = 1'b0;
    #1;
    total++;
    if ({tif.serial_out, tif.not_ready_out, tif.tx_busy, tif.error1} !== 4'b1000) begin
      bad++;
      $display("FAIL mid_async_reset: got %b want 1000",
               {tif.serial_out, tif.not_ready_out, tif.tx_busy, tif.error1});
    end
    @(negedge sample_clk);
    rstn = 1'b1;
    @(negedge sample_clk);
    tif.data_in = 8'h3C; tif.load = 1'b1;
    exp_q.push_back(8'h3C);
    @(negedge sample_clk);
    tif.load = 1'b0;
    n = cyc;
    capture(4, f, bits, s, st, bz, nr);
    total++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    if (!f || st != n + 1 || bits !== frame_of(e) || !s || bz != FL) begin
      bad++;
      $display("FAIL mid_clean_frame: got %b start %0d busy %0d want %b start %0d busy %0d",
               bits, st, bz, frame_of(e), n + 1, FL);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    int st, bz;
    logic f, s, nr;
    logic [NB-1:0] bits;
    logic [7:0] e;
    repeat (2) @(negedge sample_clk);
    tif.data_in = 8'h07; tif.load = 1'b1;
    exp_q.push_back(8'h07);
    @(negedge sample_clk);
    tif.load = 1'b0;
    capture(4, f, bits, s, st, bz, nr);
    total++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    if (!f || bits !== frame_of(e) || bits[9] !== 1'b1 || !s) begin
      bad++;
      $display("FAIL parity_frame: got %b want %b", bits, frame_of(e));
    end
    total++;
    if (bz != 88) begin
      bad++;
      $display("FAIL parity_length: got %0d busy cycles want 88", bz);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_reset_midframe();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d leftover bytes want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout at cycle %0d want completion", cyc);
    $fatal(1, "watchdog");
  end
endmodule
